// File: rtl/nibble_serial_adder16.sv
// Purpose : nibble-serial WIDTH-bit adder around one 4-bit carry_skip_adder, LS nibble first.
// Latency : done pulses WIDTH/4 cycles after the start capture edge; issue interval WIDTH/4+2.
// Backpr. : no queuing; start is ignored while busy, so callers must wait for busy=0.
//
// Ports: clk, rst (async, active-high); start/a/b/cin request (sampled in IDLE only);
//        busy (ADD or DONE), done (one-cycle pulse), sum/cout (registered, held until
//        next completion), ovf (signed overflow, only when SIGNED_OVF_EN is defined).
// Build option: `define SIGNED_OVF_EN adds the ovf port and its register.

// 4-bit carry-skip stage: ripple carry, bypassed by cin when every bit propagates.
module carry_skip_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[3:0];
  // With all bits propagating, the ripple carry equals cin, so the skip is exact.
  assign cout = (&p) ? cin : c[4];
endmodule

module nibble_serial_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SIGNED_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_next;
  logic [IW-1:0]     idx;
  logic              c;
  logic [3:0]        nib_sum;
  logic              nib_cout;
  logic              last;

  assign last = (idx == LAST);

  carry_skip_adder u_csa (
    .a    (a_r[{idx, 2'b00} +: 4]),
    .b    (b_r[{idx, 2'b00} +: 4]),
    .cin  (c),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Accumulator with the current nibble merged in; on the last nibble this is the final sum.
  always_comb begin
    acc_next = acc;
    acc_next[{idx, 2'b00} +: 4] = nib_sum;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ADD;
      S_ADD:   if (last)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      idx  <= '0;
      c    <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            idx <= '0;
            c   <= cin;
          end
        end
        S_ADD: begin
          acc <= acc_next;
          c   <= nib_cout;
          if (last) begin
            sum  <= acc_next;
            cout <= nib_cout;
`ifdef SIGNED_OVF_EN
            // Operands share a sign but the result's sign differs.
            ovf  <= (a_r[WIDTH-1] ~^ b_r[WIDTH-1]) & (acc_next[WIDTH-1] ^ a_r[WIDTH-1]);
`endif
          end else begin
            // Hold on the last nibble so idx never wraps inside an operation.
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder16.sv
module tb_nibble_serial_adder16;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SIGNED_OVF_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder16 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SIGNED_OVF_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation from IDLE and checks done timing and the result.
  // Called 1 time unit after a rising edge; returns 1 time unit after E(NIB+1),
  // so an immediate next call is captured at E(NIB+2).
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    logic early;
    start = 1'b1; a = av; b = bv; cin = cv;
    tick();                                   // E0: capture
    start = 1'b0;
    check({tag, "_busy_add"}, busy, 1);
    early = 1'b0;
    for (int k = 1; k < NIB; k++) begin
      if (done) early = 1'b1;
      tick();
    end
    if (done) early = 1'b1;
    check({tag, "_early_done"}, early, 0);
    tick();                                   // E(NIB): DONE entry
    check({tag, "_done"}, done, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef SIGNED_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo) begin end
`endif
    tick();                                   // E(NIB+1): back to IDLE
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    int ndone;
    logic        seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] rr;
    logic        ro;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();
    tick();
    check("idle_busy", busy, 0);

    // Directed vectors
    run_op("ffff_p1",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("skip_c1",  16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("skip_c0",  16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op("mix",      16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("max_c1",   16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_op("nib_carry",16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("no_ovf",   16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0);

    // start held high through ADD and DONE with other operands: must be ignored
    start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    tick();                                   // E0
    a = 16'h1234; b = 16'h1111;
    ndone = 0;
    for (int k = 1; k <= NIB; k++) begin
      if (done) ndone++;
      tick();
    end
    if (done) ndone++;
    check("ign_sum", sum, 16'h3333);
    tick();                                   // DONE -> IDLE, start still high here
    start = 1'b0;
    for (int k = 0; k < NIB + 2; k++) begin
      if (done) ndone++;
      tick();
    end
    check("ign_one_done", ndone, 1);
    check("ign_sum_held", sum, 16'h3333);
    check("ign_idle", busy, 0);
    run_op("after_ign", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Reset in the middle of ADD after two nibbles
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    tick();                                   // E0
    start = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_done", done, 0);
    tick();
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < NIB + 3; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check("arst_no_done", seen, 0);
    run_op("post_rst", 16'h00FF, 16'h0101, 1'b1, 16'h0201, 1'b0, 1'b0);

    // Random back-to-back at the minimum issue interval
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rr = 17'(ra) + 17'(rb) + 17'(rc);
      ro = (ra[15] == rb[15]) && (rr[15] != ra[15]);
      run_op("rnd", ra, rb, rc, rr[15:0], rr[16], ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
